sum_bcd_display: RTL and testbench
==================================

SUM_BCD_DISPLAY -- requirements
Module: sum_bcd_display

Interface
REQ-001 Parameter: W, 5, width of the binary sum accepted from the upstream 4-bit adder (sum plus carry-out); legal range 1..6.
REQ-002 Port: CLOCK_50  input  1  sole clock, rising-edge active.
REQ-003 Port: RESET  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to convert sum_in; sampled on the rising edge of CLOCK_50.
REQ-005 Port: sum_in  input  W  unsigned binary sum to convert.
REQ-006 Port: busy  output  1  high while a conversion is in progress.
REQ-007 Port: done  output  1  one-cycle pulse when new digits are valid.
REQ-008 Port: bcd_tens  output  4  BCD tens digit of the last completed conversion.
REQ-009 Port: bcd_ones  output  4  BCD ones digit of the last completed conversion.
REQ-010 Port: HEX1  output  7  active-low 7-segment pattern for bcd_tens; present only with SEG7_DECODE_EN.
REQ-011 Port: HEX0  output  7  active-low 7-segment pattern for bcd_ones; present only with SEG7_DECODE_EN.

Function
REQ-012 The block SHALL convert sum_in to two BCD digits using sequential shift-and-add-3, one bit per clock cycle, MSB first.
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture sum_in into a W-bit shift register, clear the 8-bit BCD scratch register, clear the bit counter and enter SHIFT.
REQ-015 In SHIFT, on each cycle, the block SHALL first add 3 to any scratch nibble that is >=5, then shift {scratch, shift register} left by one bit.
REQ-016 In SHIFT, the block SHALL increment the bit counter and enter DONE after exactly W shifts.
REQ-017 In DONE, the block SHALL load bcd_tens and bcd_ones from scratch, assert done for exactly that cycle and return to IDLE.
REQ-018 Latency SHALL be W+1 cycles from the edge that accepts start to the edge at which done is asserted; for W=5, done is asserted on the 6th edge after acceptance.
REQ-019 busy SHALL be high in the SHIFT and DONE states and low in IDLE.
REQ-020 start SHALL be ignored while busy=1; a request is not queued.
REQ-021 bcd_tens and bcd_ones SHALL hold their value between conversions and change only in DONE.
REQ-022 Inputs 0..(2^W-1) SHALL produce correct digits: sum_in=0 gives 0/0, and sum_in=31 with W=5 gives 3/1.
REQ-023 start held high continuously SHALL produce back-to-back conversions: IDLE for one cycle, then a new capture.
REQ-024 sum_in changes during SHIFT SHALL NOT affect the result of the conversion in progress.

Reset
REQ-025 RESET=1 SHALL, asynchronously, force the FSM to IDLE and clear the counter, scratch and shift registers.
REQ-026 RESET=1 SHALL force busy=0, done=0, bcd_tens=0 and bcd_ones=0.
REQ-027 RESET=1 with SEG7_DECODE_EN defined SHALL force HEX1 and HEX0 to the pattern for digit 0 (7'b1000000).
REQ-028 A RESET asserted mid-conversion SHALL abort the conversion with no done pulse.
REQ-029 After RESET is released, the first rising edge SHALL already be able to accept start.

Configuration
REQ-030 Macro SEG7_DECODE_EN defined: HEX1 and HEX0 SHALL exist, each driven combinationally from the registered BCD digits.
REQ-031 Segment encoding SHALL be active-low, bit order g..a (bit 6 = g), using the standard 0-9 patterns.
REQ-032 Macro SEG7_DECODE_EN undefined: HEX1, HEX0 and the decoder SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-033 A shared package SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the ten 7-segment digit pattern constants.
REQ-034 The 7-segment decoding SHALL be one sub-module, seg7_decoder (4-bit BCD in, 7-bit active-low out), instantiated twice under SEG7_DECODE_EN.

Verification
REQ-035 Reset, then sum_in=5'd0 with a 1-cycle start -> busy high for 6 cycles, a done pulse on the 6th edge, bcd_tens=0, bcd_ones=0.
REQ-036 sum_in=5'd31 -> bcd_tens=3, bcd_ones=1; with SEG7_DECODE_EN, HEX1=7'b0110000 and HEX0=7'b1111001.
REQ-037 sum_in=5'd19 started, then sum_in changed to 5'd7 and start pulsed during SHIFT -> single result 1/9, second start ignored, exactly one done pulse.
REQ-038 RESET asserted on the 3rd SHIFT cycle of sum_in=5'd25 -> all outputs 0 immediately, no done pulse; a subsequent start with 5'd25 -> 2/5.
REQ-039 start held high with sum_in=5'd10, then 5'd16 -> consecutive done pulses 7 cycles apart, outputs 1/0 then 1/6.
REQ-040 Exhaustive sweep of sum_in 0..31 -> every result equals (sum_in/10, sum_in%10).

Source files
------------

// File: rtl/sum_bcd_display_pkg.sv
// sum_bcd_display_pkg: FSM state type and active-low 7-segment digit patterns (bit 6 = g).
package sum_bcd_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/sum_bcd_display_seg7.sv
// seg7_decoder: BCD digit to active-low 7-segment pattern, blank for non-decimal codes.
module seg7_decoder
  import sum_bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/sum_bcd_display.sv
// sum_bcd_display: sequential shift-and-add-3 binary to two-digit BCD converter.
// Define SEG7_DECODE_EN to add the HEX1/HEX0 7-segment outputs.
module sum_bcd_display
  import sum_bcd_display_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         CLOCK_50,
  input  logic         RESET,
  input  logic         start,
  input  logic [W-1:0] sum_in,
  output logic         busy,
  output logic         done,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_ones
`ifdef SEG7_DECODE_EN
  ,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX0
`endif
);
  localparam int CW = $clog2(W + 1);
  state_t state;
  logic [W-1:0] sreg;
  logic [7:0] scratch, adj;
  logic [W+7:0] nxt;
  logic [CW-1:0] cnt;
  // correct each nibble before the shift so it stays a valid BCD digit afterwards
  assign adj = {scratch[7:4] + (scratch[7:4] >= 4'd5 ? 4'd3 : 4'd0),
                scratch[3:0] + (scratch[3:0] >= 4'd5 ? 4'd3 : 4'd0)};
  assign nxt = {adj, sreg} << 1;
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      sreg     <= '0;
      scratch  <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_tens <= '0;
      bcd_ones <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sreg    <= sum_in;
          scratch <= '0;
          cnt     <= '0;
          busy    <= 1'b1;
          state   <= SHIFT;
        end
        SHIFT: begin
          scratch <= nxt[W+7:W];
          sreg    <= nxt[W-1:0];
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= DONE;
        end
        DONE: begin
          bcd_tens <= scratch[7:4];
          bcd_ones <= scratch[3:0];
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SEG7_DECODE_EN
  seg7_decoder u_tens (.bcd(bcd_tens), .seg(HEX1));
  seg7_decoder u_ones (.bcd(bcd_ones), .seg(HEX0));
`endif
endmodule

// File: tb/tb_sum_bcd_display.sv
// tb_sum_bcd_display: directed checks of latency, busy/done timing, reset abort and digit values.
module tb_sum_bcd_display;
  logic CLOCK_50 = 1'b0;
  logic RESET = 1'b1;
  logic start = 1'b0;
  logic [4:0] sum_in = '0;
  logic busy, done;
  logic [3:0] bcd_tens, bcd_ones;
  int n_run = 0;
  int n_fail = 0;
`ifdef SEG7_DECODE_EN
  logic [6:0] HEX1, HEX0;
`endif
  sum_bcd_display #(.W(5)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .start(start),
    .sum_in(sum_in),
    .busy(busy),
    .done(done),
    .bcd_tens(bcd_tens),
    .bcd_ones(bcd_ones)
`ifdef SEG7_DECODE_EN
    ,
    .HEX1(HEX1),
    .HEX0(HEX0)
`endif
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask
  task automatic conv(input logic [4:0] v, input logic [3:0] t, input logic [3:0] o);
    int lat, busy_n;
    sum_in = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 20) begin
      busy_n += busy;
      tick();
      lat++;
    end
    check("latency", lat, 6);
    check("busy_cycles", busy_n, 6);
    check("busy_low_at_done", busy, 0);
    check("tens", bcd_tens, t);
    check("ones", bcd_ones, o);
    tick();
    check("done_one_cycle", done, 0);
  endtask
  initial begin
    int lat, dones;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tens", bcd_tens, 0);
    check("rst_ones", bcd_ones, 0);
`ifdef SEG7_DECODE_EN
    check("rst_hex1", HEX1, 7'b1000000);
    check("rst_hex0", HEX0, 7'b1000000);
`endif
    tick();
    RESET = 1'b0;
    conv(5'd0, 4'd0, 4'd0);
    conv(5'd31, 4'd3, 4'd1);
`ifdef SEG7_DECODE_EN
    check("hex1_3", HEX1, 7'b0110000);
    check("hex0_1", HEX0, 7'b1111001);
`endif
    sum_in = 5'd19;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    sum_in = 5'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      dones += done;
      tick();
    end
    check("ignored_start_dones", dones, 1);
    check("ignored_start_tens", bcd_tens, 1);
    check("ignored_start_ones", bcd_ones, 9);
    check("ignored_start_idle", busy, 0);
    sum_in = 5'd25;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_tens", bcd_tens, 0);
    check("abort_ones", bcd_ones, 0);
    tick();
    RESET = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      dones += done;
      tick();
    end
    check("abort_no_done", dones, 0);
    conv(5'd25, 4'd2, 4'd5);
    sum_in = 5'd10;
    start = 1'b1;
    tick();
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b_first_latency", lat, 6);
    check("b2b_first_tens", bcd_tens, 1);
    check("b2b_first_ones", bcd_ones, 0);
    sum_in = 5'd16;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 20);
    start = 1'b0;
    check("b2b_gap", lat, 7);
    check("b2b_second_tens", bcd_tens, 1);
    check("b2b_second_ones", bcd_ones, 6);
    tick();
    tick();
    for (int i = 0; i < 32; i++) conv(5'(i), 4'(i / 10), 4'(i % 10));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
